// File: rtl/seq_frame_gen.sv
// Serial frame generator. It takes one parallel word over a valid/ready
// handshake and sends it on a 1-bit line as: sync preamble, data MSB-first,
// then an even-parity bit. A fixed number of idle gap cycles follows each frame.
module seq_frame_gen #(
    parameter int                 WIDTH      = 8,
    parameter int                 PRE_LEN    = 4,
    parameter logic [PRE_LEN-1:0] PREAMBLE   = 4'b1011,
    parameter int                 GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    // One counter serves every timed state. It is sized for the longest of them.
    localparam int MAX_A = (PRE_LEN > WIDTH) ? PRE_LEN : WIDTH;
    localparam int MAXV  = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CW    = (MAXV > 0) ? $clog2(MAXV + 1) : 1;

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [WIDTH-1:0]   word, word_n;
    logic [PRE_LEN-1:0] pre_sh;
    logic [WIDTH-1:0]   dat_sh;
    logic               out_n, vld_n, busy_n, done_n;

    assign load_ready = (state == IDLE);

    // Next state, counter and word. The registered outputs are then derived
    // from the state and counter of the next cycle, so every output bit is a
    // flop and the first preamble bit appears right after the accept edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        word_n  = word;
        out_n   = 1'b0;
        vld_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        pre_sh  = '0;
        dat_sh  = '0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (load_valid) begin
                    state_n = PRE;
                    word_n  = load_data;
                end
            end
            PRE: if (cnt == PRE_LAST) begin
                state_n = DATA;
                cnt_n   = '0;
            end
            DATA: if (cnt == DATA_LAST) begin
                state_n = PAR;
                cnt_n   = '0;
            end
            PAR: begin
                cnt_n = '0;
                if (GAP_CYCLES == 0) state_n = IDLE;
                else                 state_n = GAP;
            end
            GAP: if (cnt == GAP_LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Left-shifting by the bit index puts the bit being sent in the MSB.
        // This avoids a variable reverse index.
        pre_sh = PREAMBLE << cnt_n;
        dat_sh = word_n << cnt_n;

        case (state_n)
            PRE:  begin out_n = pre_sh[PRE_LEN-1]; vld_n = 1'b1; busy_n = 1'b1; end
            DATA: begin out_n = dat_sh[WIDTH-1];   vld_n = 1'b1; busy_n = 1'b1; end
            PAR:  begin out_n = ^word_n; vld_n = 1'b1; busy_n = 1'b1; done_n = 1'b1; end
            GAP:  busy_n = 1'b1;
            default: ;
        endcase
    end

    // State, counter, word and registered outputs. Reset drops any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            word      <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            word      <= word_n;
            out       <= out_n;
            out_valid <= vld_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_frame_gen.sv
// Bench for seq_frame_gen. Two instances share the same stimulus: one with a
// 2-cycle gap and one with no gap. Expected frames are queued at the accept
// edge and popped as the serial bits come out.
module tb_seq_frame_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       ready0, out0, ov0, busy0, done0;
    logic       ready1, out1, ov1, busy1, done1;

    seq_frame_gen #(.WIDTH(8), .PRE_LEN(4), .PREAMBLE(4'b1011), .GAP_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready0), .out(out0), .out_valid(ov0), .busy(busy0), .done(done0)
    );

    seq_frame_gen #(.WIDTH(8), .PRE_LEN(4), .PREAMBLE(4'b1011), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready1), .out(out1), .out_valid(ov1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Each entry is {serial bit, done flag}.
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    int  run0 = 0, run1 = 0, gap0 = -1, gap1 = -1;
    bit  seen0 = 0, seen1 = 0;
    logic [3:0] win = 4'b0000;
    bit  det_hit = 0;

    task automatic push_frame(input logic [7:0] d);
        logic [3:0] pre;
        pre = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            q0.push_back({pre[i], 1'b0});
            q1.push_back({pre[i], 1'b0});
        end
        for (int i = 7; i >= 0; i--) begin
            q0.push_back({d[i], 1'b0});
            q1.push_back({d[i], 1'b0});
        end
        q0.push_back({^d, 1'b1});
        q1.push_back({^d, 1'b1});
    endtask

    // Monitor for the 2-gap instance. It also runs a 1011 window detector on the line.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset) begin
            seen0 = 0;
            run0  = 0;
        end else if (ov0) begin
            if (q0.size() == 0) chk("unexpected_bit0", 1, 0);
            else begin
                e = q0.pop_front();
                chk("bit0", out0, e[1]);
                chk("done0", done0, e[0]);
                chk("busy_in_frame0", busy0, 1);
            end
            win = {win[2:0], out0};
            if (win == 4'b1011) det_hit = 1;
            if (seen0 && run0 > 0) gap0 = run0;
            run0  = 0;
            seen0 = 1;
        end else begin
            chk("idle_out0", out0, 0);
            chk("idle_done0", done0, 0);
            if (seen0) run0++;
        end
    end

    // Monitor for the no-gap instance.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!reset) begin
            seen1 = 0;
            run1  = 0;
        end else if (ov1) begin
            if (q1.size() == 0) chk("unexpected_bit1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("bit1", out1, e[1]);
                chk("done1", done1, e[0]);
            end
            if (seen1 && run1 > 0) gap1 = run1;
            run1  = 0;
            seen1 = 1;
        end else begin
            chk("idle_done1", done1, 0);
            if (seen1) run1++;
        end
    end

    // Present one word for a single accept edge once both instances are idle.
    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(ready0 && ready1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", 0, 1);
        load_valid = 1'b1;
        load_data  = d;
        push_frame(d);
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(q0.size() == 0 && q1.size() == 0 && ready0 && ready1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int n;
        // Reset held with load_valid high: nothing may start.
        reset = 1'b0;
        load_valid = 1'b1;
        load_data = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready0, 1);
        chk("rst_out", out0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_ov1", ov1, 0);
        load_valid = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", ready0, 1);
        chk("post_rst_busy", busy0, 0);

        // 0xA5 frame, then the gap cycles.
        send(8'hA5);
        n = 0;
        @(negedge clk);
        while (!done0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done0, 1);
        @(negedge clk);
        chk("gap1_busy", busy0, 1);
        chk("gap1_ov", ov0, 0);
        chk("gap1_ready", ready0, 0);
        chk("nogap_ready", ready1, 1);
        chk("nogap_busy", busy1, 0);
        @(negedge clk);
        chk("gap2_busy", busy0, 1);
        chk("gap2_ready", ready0, 0);
        @(negedge clk);
        chk("after_gap_ready", ready0, 1);
        chk("after_gap_busy", busy0, 0);

        // 0x01: the preamble must look like a 1011 hit to a detector.
        det_hit = 0;
        send(8'h01);
        wait_idle();
        chk("detector_hit", det_hit, 1);

        // 0x3C with a 0xFF load pulse during DATA, which must be ignored.
        send(8'h3C);
        repeat (4) @(posedge clk);
        #1;
        chk("in_data_busy", busy0, 1);
        load_valid = 1'b1;
        load_data  = 8'hFF;
        @(posedge clk);
        #1 load_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("no_queued_frame", ov0, 0);

        // 0xF0 aborted by an asynchronous mid-clock reset in the 3rd DATA cycle.
        send(8'hF0);
        repeat (6) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("abort_out", out0, 0);
        chk("abort_ov", ov0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_ready", ready0, 1);
        chk("abort_ov1", ov1, 0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("abort_idle_ready", ready0, 1);
        send(8'h0F);
        wait_idle();

        // Back-to-back frames with load_valid held high.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 8'h81;
        push_frame(8'h81);
        @(posedge clk);
        #1 load_data = 8'h7E;
        push_frame(8'h7E);
        n = 0;
        @(negedge clk);
        while (!ready0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("b2b_timeout", 0, 1);
        @(posedge clk);
        #1 load_valid = 1'b0;
        wait_idle();
        chk("b2b_gap_g2", gap0, 3);
        chk("b2b_gap_g0", gap1, 1);
        chk("queue_empty0", q0.size(), 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
